udm_memsplit_ram: RTL and testbench
===================================

Name: udm_memsplit_ram

Overview:
- Bus responder (slave) for the split request/response memory bus driven by the UART debug master.
- Holds a word-organised on-chip RAM.
- Accepts requests over the req/ack channel and returns read data over the resp channel after a fixed, parameterised latency.
- Used as a debug scratch memory and as the reference target when bringing up the debug master on FPGA boards.

Parameters:
- BASE_ADDR, 32'h0000_0000, byte address of word 0; must be 4-byte aligned.
- DEPTH, 1024, number of 32-bit words; power of two, minimum 2.
- READ_LATENCY, 1, cycles from accepted read to resp pulse; range 1..8.
- ERR_DATA, 32'hDEAD_BEEF, read data returned for out-of-range addresses.

Ports:
- clk_i  input  1  clock; all logic on rising edge.
- rst_i  input  1  reset, asynchronous, active-low.
- bus_req_i  input  1  request valid.
- bus_we_i  input  1  1 = write, 0 = read.
- bus_addr_bi  input  32  byte address.
- bus_be_bi  input  4  byte enables; bit n covers wdata[8n+7:8n].
- bus_wdata_bi  input  32  write data.
- bus_ack_o  output  1  request accepted this cycle.
- bus_resp_o  output  1  read response valid; one-cycle pulse.
- bus_rdata_bo  output  32  read data; qualified by bus_resp_o.

Behaviour:
- Handshake:
  - bus_ack_o = bus_req_i & ~stall. This is combinational, with no added cycle.
  - A transaction is accepted on any rising edge where bus_req_i = 1 and bus_ack_o = 1.
  - The initiator holds req, we, addr, be and wdata stable until ack.
- Address decode:
  - In range if BASE_ADDR <= addr < BASE_ADDR + 4*DEPTH.
  - Word index = (addr - BASE_ADDR) >> 2.
  - addr[1:0] is ignored.
- Write:
  - On the accepting edge, each byte with be[n] = 1 is updated. be = 0 is a legal no-op.
  - Writes produce no response.
  - An out-of-range write is acked and dropped.
- Read:
  - bus_resp_o = 1 for exactly one cycle, exactly READ_LATENCY cycles after the accepting edge.
  - READ_LATENCY = 1 means resp is high in the cycle following ack.
  - bus_be_bi is ignored for reads.
  - rdata returns the full word: RAM contents for an in-range address, ERR_DATA otherwise.
- Pipeline:
  - Implemented as a READ_LATENCY-deep valid/data shift pipeline.
  - Accepts one read per cycle, fully pipelined.
  - Responses are returned strictly in request order.
  - No backpressure exists on resp; the responder never drops or delays a response once a read is acked.
- Ordering:
  - A read accepted the cycle after a write to the same word returns the written data (write-first).
  - Reads and writes share one channel, so a read and a write are never accepted in the same cycle.
- bus_rdata_bo is forced to 32'h0 whenever bus_resp_o = 0.
- Reset (rst_i low, asynchronous):
  - Clears the pipeline valid bits.
  - Holds bus_resp_o = 0 and bus_rdata_bo = 0.
  - Holds bus_ack_o at its combinational value with stall forced to 0.
  - RAM contents are not reset.
  - Reads in flight at reset assertion are discarded and no resp is issued for them.
- Deassertion of reset is synchronised externally; the block requires no cycles after it before accepting requests.

Optional Feature:
- Macro: UDM_MEMSPLIT_RAM_STALL_EN.
- When defined:
  - A 16-bit Fibonacci LFSR (taps 16,14,13,11) is seeded to 16'hACE1 on reset and advances every clock.
  - stall = (lfsr[1:0] == 2'b00), giving about 25% wait states on the ack channel, used to stress the initiator's req/ack handling.
  - Read latency, measured from the accepting edge, is unchanged.
- When undefined: no LFSR is built, stall = 0, and bus_ack_o = bus_req_i.

Test Plan:
- Write then read back: write addr BASE+0x10, be=4'hF, wdata=32'h1234_5678; read same addr -> ack same cycle as req, resp 1 cycle later with rdata=32'h1234_5678; rdata=0 outside resp.
- Byte masking: word preloaded 32'hAABB_CCDD; write be=4'b0101, wdata=32'h1122_3344 -> read returns 32'hAA22_CC44.
- Pipelined reads, READ_LATENCY=3: four back-to-back reads of words 0..3 holding 0,1,2,3 -> four consecutive resp pulses starting 3 cycles after the first ack, data 0,1,2,3 in order.
- Out of range with DEPTH=16, BASE 0: write 0x40 then read 0x40 -> write acked with no RAM change; read resp with rdata=32'hDEAD_BEEF; word 0 unchanged.
- Reset mid-flight, READ_LATENCY=4: read acked, rst_i low 2 cycles later for 1 cycle -> no resp pulse ever issued; a subsequent read of the same address returns pre-reset RAM data.
- With UDM_MEMSPLIT_RAM_STALL_EN: 200 random reads/writes with req held until ack -> at least one cycle with req=1 and ack=0; all read data matches a scoreboard; every resp arrives READ_LATENCY cycles after its ack.

Source files
------------

// File: rtl/udm_memsplit_ram.sv
// Word-organised RAM responder for the split req/ack + resp debug bus.
// Optional ack wait-state injection: define UDM_MEMSPLIT_RAM_STALL_EN.
module udm_memsplit_ram #(
   parameter logic [31:0] BASE_ADDR    = 32'h0000_0000,
   parameter int unsigned DEPTH        = 1024,
   parameter int unsigned READ_LATENCY = 1,
   parameter logic [31:0] ERR_DATA     = 32'hDEAD_BEEF
) (
   input  logic        clk_i,
   input  logic        rst_i,
   input  logic        bus_req_i,
   input  logic        bus_we_i,
   input  logic [31:0] bus_addr_bi,
   input  logic [3:0]  bus_be_bi,
   input  logic [31:0] bus_wdata_bi,
   output logic        bus_ack_o,
   output logic        bus_resp_o,
   output logic [31:0] bus_rdata_bo
);

   localparam int unsigned AW   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam logic [32:0] SPAN = 33'(DEPTH) << 2;

   if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
      $error("udm_memsplit_ram: DEPTH must be a power of two >= 2");
   end
   if (READ_LATENCY < 1 || READ_LATENCY > 8) begin : g_bad_lat
      $error("udm_memsplit_ram: READ_LATENCY must be 1..8");
   end
   if (BASE_ADDR[1:0] != 2'b00) begin : g_bad_base
      $error("udm_memsplit_ram: BASE_ADDR must be word aligned");
   end

   logic          w_stall;
   logic          w_acc_rd;
   logic          w_acc_wr;
   logic [32:0]   w_diff;
   logic          w_in_range;
   logic [AW-1:0] w_idx;
   logic [31:0]   w_rd_word;

   logic [31:0]   r_mem [DEPTH];
   logic          r_vld [READ_LATENCY];
   logic [31:0]   r_dat [READ_LATENCY];

`ifdef UDM_MEMSPLIT_RAM_STALL_EN
   logic [15:0]   r_lfsr;
   logic          w_fb;

   // Fibonacci LFSR x^16+x^14+x^13+x^11+1 drives pseudo-random wait states
   assign w_fb = r_lfsr[15] ^ r_lfsr[13] ^ r_lfsr[12] ^ r_lfsr[10];

   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) r_lfsr <= 16'hACE1;
      else        r_lfsr <= {r_lfsr[14:0], w_fb};
   end

   assign w_stall = rst_i & (r_lfsr[1:0] == 2'b00);
`else
   assign w_stall = 1'b0;
`endif

   assign bus_ack_o = bus_req_i & ~w_stall;
   assign w_acc_rd  = bus_ack_o & ~bus_we_i;
   assign w_acc_wr  = bus_ack_o &  bus_we_i;

   // 33-bit difference: a borrow lands above SPAN, so one compare covers both bounds
   assign w_diff     = {1'b0, bus_addr_bi} - {1'b0, BASE_ADDR};
   assign w_in_range = (w_diff < SPAN);
   assign w_idx      = w_diff[AW+1:2];
   assign w_rd_word  = w_in_range ? r_mem[w_idx] : ERR_DATA;

   // RAM array: byte-masked writes, contents survive reset
   always_ff @(posedge clk_i) begin
      if (w_acc_wr && w_in_range) begin
         for (int b = 0; b < 4; b++) begin
            if (bus_be_bi[b]) r_mem[w_idx][8*b +: 8] <= bus_wdata_bi[8*b +: 8];
         end
      end
   end

   // Read pipeline; data is zeroed alongside an empty slot so the output needs no mux
   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
         for (int i = 0; i < READ_LATENCY; i++) begin
            r_vld[i] <= 1'b0;
            r_dat[i] <= 32'h0;
         end
      end else begin
         r_vld[0] <= w_acc_rd;
         r_dat[0] <= w_acc_rd ? w_rd_word : 32'h0;
         for (int i = 1; i < READ_LATENCY; i++) begin
            r_vld[i] <= r_vld[i-1];
            r_dat[i] <= r_dat[i-1];
         end
      end
   end

   assign bus_resp_o   = r_vld[READ_LATENCY-1];
   assign bus_rdata_bo = r_dat[READ_LATENCY-1];

endmodule

// File: tb/tb_udm_memsplit_ram.sv
// Directed + random bench for udm_memsplit_ram (DEPTH=16, READ_LATENCY=3, BASE 0).
module tb_udm_memsplit_ram;

   localparam int unsigned LAT = 3;
   localparam int unsigned DEP = 16;

   typedef struct {
      int          cyc;
      logic [31:0] data;
   } exp_t;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        bus_req = 1'b0;
   logic        bus_we = 1'b0;
   logic [31:0] bus_addr = 32'h0;
   logic [3:0]  bus_be = 4'h0;
   logic [31:0] bus_wdata = 32'h0;
   logic        bus_ack;
   logic        bus_resp;
   logic [31:0] bus_rdata;

   int          total = 0;
   int          bad = 0;
   int          cyc = 0;
   bit          saw_stall = 1'b0;
   exp_t        q[$];
   logic [31:0] tm [DEP];

   udm_memsplit_ram #(
      .BASE_ADDR   (32'h0000_0000),
      .DEPTH       (DEP),
      .READ_LATENCY(LAT),
      .ERR_DATA    (32'hDEAD_BEEF)
   ) dut (
      .clk_i       (clk),
      .rst_i       (rst_n),
      .bus_req_i   (bus_req),
      .bus_we_i    (bus_we),
      .bus_addr_bi (bus_addr),
      .bus_be_bi   (bus_be),
      .bus_wdata_bi(bus_wdata),
      .bus_ack_o   (bus_ack),
      .bus_resp_o  (bus_resp),
      .bus_rdata_bo(bus_rdata)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // Response monitor: every cycle checks resp against the expected-arrival queue
   always @(negedge clk) begin
      bit   exp_now;
      exp_t e;
      while (q.size() > 0 && q[0].cyc < cyc) void'(q.pop_front());
      exp_now = (q.size() > 0) && (q[0].cyc == cyc);
      chk("resp_valid", 32'(bus_resp), 32'(exp_now));
      if (exp_now) begin
         e = q.pop_front();
         if (bus_resp) chk("resp_data", bus_rdata, e.data);
      end else if (!bus_resp) begin
         chk("rdata_idle", bus_rdata, 32'h0);
      end
   end

   // Issue one request and hold it until acked (bounded)
   task automatic xfer(input logic we, input logic [31:0] a, input logic [3:0] be,
                       input logic [31:0] wd, input logic [31:0] exp_rd);
      int waits = 0;
      bit done = 1'b0;
      bus_req = 1'b1; bus_we = we; bus_addr = a; bus_be = be; bus_wdata = wd;
      while (!done) begin
         @(negedge clk);
         if (bus_ack) begin
            done = 1'b1;
            if (!we) q.push_back('{cyc + LAT, exp_rd});
         end else begin
            saw_stall = 1'b1;
            waits++;
            if (waits > 64) begin
               chk("ack_timeout", 32'(waits), 32'd64);
               done = 1'b1;
            end
         end
      end
      @(posedge clk); #1;
      bus_req = 1'b0; bus_we = 1'b0;
   endtask

   task automatic wr(input logic [31:0] a, input logic [3:0] be, input logic [31:0] wd);
      if (a < 32'(4*DEP)) begin
         for (int b = 0; b < 4; b++)
            if (be[b]) tm[a[5:2]][8*b +: 8] = wd[8*b +: 8];
      end
      xfer(1'b1, a, be, wd, 32'h0);
   endtask

   task automatic rd(input logic [31:0] a, input logic [31:0] exp);
      xfer(1'b0, a, 4'h0, 32'h0, exp);
   endtask

   task automatic drain();
      int n = 0;
      while (q.size() > 0 && n < 30) begin
         @(posedge clk); n++;
      end
      #1;
      chk("drain", 32'(q.size()), 32'd0);
   endtask

   initial begin
      // reset state, ack combinational with no stall during reset
      repeat (2) @(negedge clk);
      chk("rst_resp", 32'(bus_resp), 32'd0);
      chk("rst_rdata", bus_rdata, 32'h0);
      chk("rst_ack_idle", 32'(bus_ack), 32'd0);
      bus_req = 1'b1; #1;
      chk("rst_ack_req", 32'(bus_ack), 32'd1);
      bus_req = 1'b0;
      @(posedge clk); #1;
      rst_n = 1'b1;

      // write then read back, write-first, low address bits ignored
      wr(32'h10, 4'hF, 32'h1234_5678);
      rd(32'h10, 32'h1234_5678);
      rd(32'h13, 32'h1234_5678);

      // byte masking and be=0 no-op
      wr(32'h14, 4'hF, 32'hAABB_CCDD);
      wr(32'h14, 4'b0101, 32'h1122_3344);
      rd(32'h14, 32'hAA22_CC44);
      wr(32'h14, 4'h0, 32'hFFFF_FFFF);
      rd(32'h16, 32'hAA22_CC44);

      // back-to-back pipelined reads
      for (int i = 0; i < 4; i++) wr(32'(4*i), 4'hF, 32'(i));
      rd(32'h0, 32'h0);
      rd(32'h4, 32'h1);
      rd(32'h8, 32'h2);
      rd(32'hC, 32'h3);
      drain();

      // out of range: write dropped, read returns error word, word 0 untouched
      wr(32'h40, 4'hF, 32'h5555_5555);
      rd(32'h40, 32'hDEAD_BEEF);
      rd(32'hFFFF_FFFC, 32'hDEAD_BEEF);
      rd(32'h0, 32'h0);
      drain();

      for (int i = 6; i < 16; i++) wr(32'(4*i), 4'hF, 32'hC0DE_0000 + 32'(i));
      rd(32'h3C, 32'hC0DE_000F);
      drain();

      // reset with a read in flight: its response must never appear
      rd(32'h10, 32'h1234_5678);
      @(posedge clk); #1;
      rst_n = 1'b0;
      q.delete();
      bus_req = 1'b1; #1;
      chk("midrst_ack", 32'(bus_ack), 32'd1);
      bus_req = 1'b0; #1;
      chk("midrst_resp", 32'(bus_resp), 32'd0);
      @(posedge clk); #1;
      rst_n = 1'b1;
      repeat (6) @(posedge clk);
      #1;
      rd(32'h10, 32'h1234_5678);
      drain();

      // random mix against the bench memory model
      for (int n = 0; n < 200; n++) begin
         logic [31:0] a;
         a = 32'(4 * $urandom_range(0, 19)) + 32'($urandom_range(0, 3));
         if ($urandom_range(0, 1) == 1)
            wr(a, 4'($urandom_range(0, 15)), $urandom);
         else
            rd(a, (a < 32'(4*DEP)) ? tm[a[5:2]] : 32'hDEAD_BEEF);
      end
      drain();

`ifdef UDM_MEMSPLIT_RAM_STALL_EN
      chk("saw_stall", 32'(saw_stall), 32'd1);
`else
      chk("saw_stall", 32'(saw_stall), 32'd0);
`endif

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
